// File: rtl/pipe_pkg.sv
// Shared constants for the fetch unit and its prefetch queue.
package pipe_pkg;

  localparam int unsigned INSTR_W      = 32;
  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned PC_INC       = 4;

endpackage

// File: rtl/pipe_fetch_unit_if.sv
// Redirect, instruction-memory and decode-side signals of the fetch unit.
interface pipe_fetch_unit_if
  import pipe_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEFAULT,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic               redirect_valid;
  logic [XLEN-1:0]    redirect_pc;
  logic               imem_req_valid;
  logic               imem_req_ready;
  logic [XLEN-1:0]    imem_req_addr;
  logic               imem_rsp_valid;
  logic [INSTR_W-1:0] imem_rsp_data;
  logic               id_valid;
  logic               id_ready;
  logic [XLEN-1:0]    id_pc;
  logic [INSTR_W-1:0] id_instr;
  logic [CW-1:0]      occupancy;

  modport master (
    input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid,
           imem_rsp_data, id_ready,
    output imem_req_valid, imem_req_addr, id_valid, id_pc, id_instr, occupancy
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid,
           imem_rsp_data, id_ready,
    input  imem_req_valid, imem_req_addr, id_valid, id_pc, id_instr, occupancy
  );

endinterface

// File: rtl/pipe_fifo.sv
// Synchronous FIFO with same-cycle flush; pointers wrap modulo DEPTH (power of 2).
module pipe_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int unsigned   AW       = $clog2(DEPTH);
  localparam int unsigned   CW       = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full, do_push, do_pop;

  always_comb begin
    full     = (count_q == FULL_CNT);
    do_pop   = pop && !flush && (count_q != '0);
    // A push into a full queue is only legal when the head leaves in the same cycle.
    do_push  = push && !flush && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign count = count_q;

  overflow_chk : assert property (@(posedge clk) disable iff (!rst_n)
    !(push && full && !pop && !flush))
    else $error("pipe_fifo: push into full queue");

endmodule

// File: rtl/pipe_fetch_unit.sv
// Instruction fetch front end: credit-limited request issue, in-order response
// capture into a prefetch queue, and redirect flush with stale-response dropping.
module pipe_fetch_unit
  import pipe_pkg::*;
#(
  parameter int unsigned     XLEN     = XLEN_DEFAULT,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic               clk,
  input logic               rst_n,
  pipe_fetch_unit_if.master bus
);
  localparam int unsigned   CW        = $clog2(DEPTH) + 1;
  localparam int unsigned   FW        = XLEN + INSTR_W;
  localparam logic [CW:0]   DEPTH_LIM = (CW + 1)'(DEPTH);
  localparam logic [XLEN-1:0] INC     = XLEN'(PC_INC);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;

  logic [CW-1:0]   occ;
  logic [CW:0]     in_use;
  logic [FW-1:0]   head;
  logic [XLEN-1:0] target_pc;
  logic            fifo_empty;
  logic            req_valid, req_fire, rsp_keep, push, id_valid, pop;

  always_comb begin
    target_pc = bus.redirect_pc & ~XLEN'(3);
    in_use    = {1'b0, occ} + {1'b0, outstanding_q};
    req_valid = rst_n && !bus.redirect_valid && (in_use < DEPTH_LIM);
    req_fire  = req_valid && bus.imem_req_ready;
    rsp_keep  = bus.imem_rsp_valid && (drop_cnt_q == '0);
    push      = rsp_keep && !bus.redirect_valid;
    id_valid  = !fifo_empty && !bus.redirect_valid;
    pop       = id_valid && bus.id_ready;
  end

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;

    case ({req_fire, bus.imem_rsp_valid})
      2'b10:   outstanding_d = outstanding_q + CW'(1);
      2'b01:   outstanding_d = outstanding_q - CW'(1);
      default: outstanding_d = outstanding_q;
    endcase

    if (bus.redirect_valid) begin
      fetch_pc_d = target_pc;
      rsp_pc_d   = target_pc;
      // Everything still in flight belongs to the old stream, except a response landing now.
      drop_cnt_d = outstanding_q - CW'(bus.imem_rsp_valid);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + INC;
      if (rsp_keep) rsp_pc_d = rsp_pc_q + INC;
      if (bus.imem_rsp_valid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  pipe_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (bus.redirect_valid),
    .push  (push),
    .wdata ({rsp_pc_q, bus.imem_rsp_data}),
    .pop   (pop),
    .rdata (head),
    .empty (fifo_empty),
    .count (occ)
  );

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.id_valid       = id_valid;
  assign bus.id_pc          = fifo_empty ? '0 : head[FW-1 -: XLEN];
  assign bus.id_instr       = fifo_empty ? '0 : head[INSTR_W-1:0];
  assign bus.occupancy      = occ;

endmodule

// File: doc/pipe_fetch_unit.md
PIPE_FETCH_UNIT -- requirements
Module: pipe_fetch_unit

Interface
REQ-001 Parameter XLEN, default 32: PC and instruction-memory address width.
REQ-002 Parameter DEPTH, default 4: prefetch queue entries and maximum in-flight requests; must be a power of 2 and at least 2.
REQ-003 Parameter RESET_PC, default 0: first fetch address after reset.
REQ-004 Port clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port redirect_valid, input, 1 bit: taken branch or jump; flush and refetch.
REQ-007 Port redirect_pc, input, XLEN bits: redirect target.
REQ-008 Port imem_req_valid, output, 1 bit: fetch request valid.
REQ-009 Port imem_req_ready, input, 1 bit: memory accepts the request.
REQ-010 Port imem_req_addr, output, XLEN bits: word-aligned fetch address.
REQ-011 Port imem_rsp_valid, input, 1 bit: in-order response valid; responses cannot be back-pressured.
REQ-012 Port imem_rsp_data, input, 32 bits: instruction word.
REQ-013 Port id_valid, output, 1 bit: instruction available to decode.
REQ-014 Port id_ready, input, 1 bit: decode accepts; low means stall.
REQ-015 Port id_pc, output, XLEN bits: PC of the presented instruction.
REQ-016 Port id_instr, output, 32 bits: presented instruction.
REQ-017 Port occupancy, output, $clog2(DEPTH)+1 bits: current queue fill.

Function
REQ-018 Request handshake: imem_req_valid && imem_req_ready; on it, fetch_pc advances by 4 (modulo 2^XLEN).
REQ-019 imem_req_valid shall be asserted only while rst_n=1, redirect_valid=0 and (queue occupancy + outstanding requests) < DEPTH (credit rule).
REQ-020 imem_req_addr shall equal fetch_pc and shall stay stable while imem_req_valid=1 and imem_req_ready=0.
REQ-021 Outstanding count: +1 on request handshake, -1 on imem_rsp_valid; both in one cycle leaves it unchanged.
REQ-022 Kept response (drop_cnt=0): data is written to the queue tagged with rsp_pc, and rsp_pc advances by 4.
REQ-023 Stale response (drop_cnt>0): data is discarded, drop_cnt decrements, and the queue and rsp_pc are unchanged.
REQ-024 id_valid shall equal (queue non-empty && redirect_valid=0); id_pc and id_instr shall come from the queue head.
REQ-025 Latency: a kept response in cycle N appears at the head no earlier than cycle N+1; there is no response-to-id bypass.
REQ-026 A pop occurs on id_valid && id_ready; a push and a pop in the same cycle leave occupancy unchanged.
REQ-027 Full queue: the credit rule guarantees a kept response never arrives while the queue is full; an overflow shall trigger an assertion failure.
REQ-028 Empty queue with id_ready=1: id_valid=0 and there is no pop.
REQ-029 Redirect cycle, part 1: the queue is flushed and no pop occurs.
REQ-030 Redirect cycle, part 2: fetch_pc and rsp_pc load {redirect_pc[XLEN-1:2],2'b00}.
REQ-031 Redirect cycle, part 3: drop_cnt loads outstanding minus (imem_rsp_valid ? 1 : 0), so every pre-redirect request is discarded.
REQ-032 Back-to-back redirects: each one re-applies REQ-029 to REQ-031; the last one wins.
REQ-033 Redirect while drop_cnt>0 and a response arrives: REQ-031 applies using the current outstanding count.
REQ-034 Redirect does not cancel a request already accepted; the response for that request is counted as stale.

Reset
REQ-035 While rst_n=0: fetch_pc=RESET_PC, rsp_pc=RESET_PC, queue empty, outstanding=0, drop_cnt=0.
REQ-036 While rst_n=0: imem_req_valid=0, id_valid=0, id_pc=0, id_instr=0, occupancy=0.
REQ-037 Reset asserted mid-operation clears all state immediately; responses arriving after reset release for pre-reset requests are outside scope.
REQ-038 The first request may issue in the first rising edge after rst_n deasserts.

Structure
REQ-039 Package pipe_pkg shall hold INSTR_W=32, the default XLEN, and the PC increment constant 4.
REQ-040 Sub-module pipe_fifo, a synchronous FIFO parametrised in width and depth with a same-cycle flush input, stores {pc, instr}; pointers wrap modulo DEPTH.
REQ-041 The counters outstanding and drop_cnt shall each be $clog2(DEPTH)+1 bits wide.

Verification
REQ-042 Zero-wait memory (ready=1, one-cycle response) and id_ready=1: after reset with RESET_PC=0, id_pc sequence 0,4,8,12 on consecutive cycles, with no bubbles after the first.
REQ-043 id_ready=0 for 10 cycles, DEPTH=4: occupancy reaches 4, outstanding 0, no further requests; release gives 4 pops in order.
REQ-044 Redirect to 0x100 while 2 requests are outstanding: both responses are dropped and the next id_pc is 0x100.
REQ-045 Redirect to 0x103: requests start at 0x100 and id_pc=0x100.
REQ-046 Redirect on consecutive cycles to 0x40 then 0x80: only 0x80-stream instructions reach decode.
REQ-047 Assert rst_n=0 mid-stream with 3 queued entries: occupancy=0 and imem_req_valid=0 immediately; after release the first imem_req_addr is RESET_PC.
